// File: rtl/hdr_cmd_fetch_if.sv
// Handshake and regfile bus between the HDR command fetcher and its
// surroundings (i3c engine, HDR engine, register file).
interface hdr_cmd_fetch_if;
  logic        i_hdr_start;
  logic [7:0]  i_regf_rd_data;
  logic        i_ccc_done;
  logic        i_ddr_mode_done;
  logic        i_hdr_done;
  logic        o_regf_rd_en;
  logic [11:0] o_regf_addr;
  logic        o_hdr_en;
  logic        o_cp;
  logic        o_toc;
  logic [2:0]  o_mode;
  logic        o_fetch_done;
  logic        o_fetch_err;

  // Environment side: drives the engine/regfile inputs, observes the fetcher.
  modport master (
    output i_hdr_start, i_regf_rd_data, i_ccc_done, i_ddr_mode_done, i_hdr_done,
    input  o_regf_rd_en, o_regf_addr, o_hdr_en, o_cp, o_toc, o_mode,
           o_fetch_done, o_fetch_err
  );

  // Fetcher side.
  modport slave (
    input  i_hdr_start, i_regf_rd_data, i_ccc_done, i_ddr_mode_done, i_hdr_done,
    output o_regf_rd_en, o_regf_addr, o_hdr_en, o_cp, o_toc, o_mode,
           o_fetch_done, o_fetch_err
  );
endinterface

// File: rtl/hdr_cmd_fetch.sv
// HDR command fetcher: reads a command count and a list of descriptor bytes
// from the register file, presents one descriptor at a time to the HDR engine,
// prefetches the next descriptor into a shadow register, and advances on each
// segment-done pulse until the engine reports the transaction complete.
module hdr_cmd_fetch #(
  parameter logic [11:0] CMD_BASE_ADDR = 12'd400,
  parameter int          MAX_CMDS      = 8
) (
  input logic            i_sys_clk,
  input logic            i_sys_rst_n,
  hdr_cmd_fetch_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RD_CNT, WAIT_CNT, RD_DESC, WAIT_DESC, ACTIVE, PREFETCH, PF_WAIT, FINISH
  } state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic [3:0]  r_index;
  logic [7:3]  r_shadow;
  logic        r_shadow_vld;
  logic        r_pending;
  logic        r_regf_rd_en;
  logic [11:0] r_regf_addr;
  logic        r_hdr_en;
  logic        r_cp;
  logic        r_toc;
  logic [2:0]  r_mode;
  logic        r_fetch_done;
  logic        r_fetch_err;

  logic w_seg_done;
  logic w_can_adv;
  logic w_more;
  logic w_next_last;
  logic w_cnt_bad;
  logic w_abort;

  assign w_seg_done  = bus.i_ccc_done | bus.i_ddr_mode_done;
  // Only a restart-terminated HDR-DDR descriptor hands over to a successor.
  assign w_can_adv   = !r_toc && (r_mode == 3'd6);
  // Descriptors remain beyond the current one (index < count-1).
  assign w_more      = ({1'b0, r_index} + 5'd1) < {1'b0, r_count};
  // The shadow descriptor (index+1) is the last one of the list.
  assign w_next_last = ({1'b0, r_index} + 5'd2) == {1'b0, r_count};
  assign w_cnt_bad   = (bus.i_regf_rd_data == 8'd0) ||
                       (int'(bus.i_regf_rd_data) > MAX_CMDS);
  // Engine completion wins over everything, including a same-cycle segment-done.
  assign w_abort     = bus.i_hdr_done &&
                       ((r_state == ACTIVE) || (r_state == PREFETCH) || (r_state == PF_WAIT));

  // Fetch sequencer with registered outputs.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state      <= IDLE;
      r_count      <= 4'd0;
      r_index      <= 4'd0;
      r_shadow     <= 5'd0;
      r_shadow_vld <= 1'b0;
      r_pending    <= 1'b0;
      r_regf_rd_en <= 1'b0;
      r_regf_addr  <= CMD_BASE_ADDR;
      r_hdr_en     <= 1'b0;
      r_cp         <= 1'b0;
      r_toc        <= 1'b0;
      r_mode       <= 3'd0;
      r_fetch_done <= 1'b0;
      r_fetch_err  <= 1'b0;
    end else begin
      r_regf_rd_en <= 1'b0;
      r_fetch_done <= 1'b0;
      r_fetch_err  <= 1'b0;
      if (w_abort) begin
        r_state      <= FINISH;
        r_fetch_done <= 1'b1;
        r_fetch_err  <= w_more;
        r_hdr_en     <= 1'b0;
        r_pending    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.i_hdr_start) begin
              r_state      <= RD_CNT;
              r_regf_rd_en <= 1'b1;
              r_regf_addr  <= CMD_BASE_ADDR;
              r_pending    <= 1'b0;
              r_shadow_vld <= 1'b0;
            end
          end
          RD_CNT: r_state <= WAIT_CNT;
          WAIT_CNT: begin
            r_count <= bus.i_regf_rd_data[3:0];
            if (w_cnt_bad) begin
              r_state      <= FINISH;
              r_fetch_done <= 1'b1;
              r_fetch_err  <= 1'b1;
            end else begin
              r_state      <= RD_DESC;
              r_index      <= 4'd0;
              r_regf_rd_en <= 1'b1;
              r_regf_addr  <= CMD_BASE_ADDR + 12'd1;
            end
          end
          RD_DESC: r_state <= WAIT_DESC;
          WAIT_DESC: begin
            r_cp     <= bus.i_regf_rd_data[7];
            r_toc    <= bus.i_regf_rd_data[6] | (r_count == 4'd1);
            r_mode   <= bus.i_regf_rd_data[5:3];
            r_hdr_en <= 1'b1;
            r_state  <= ACTIVE;
          end
          ACTIVE: begin
            if (w_can_adv && r_shadow_vld && (w_seg_done || r_pending)) begin
              r_cp         <= r_shadow[7];
              r_toc        <= r_shadow[6] | w_next_last;
              r_mode       <= r_shadow[5:3];
              r_index      <= r_index + 4'd1;
              r_shadow_vld <= 1'b0;
              r_pending    <= 1'b0;
            end else if (w_can_adv && !r_shadow_vld && w_more) begin
              r_state      <= PREFETCH;
              r_regf_rd_en <= 1'b1;
              r_regf_addr  <= CMD_BASE_ADDR + 12'd2 + {8'd0, r_index};
              r_pending    <= r_pending | w_seg_done;
            end
          end
          PREFETCH: begin
            r_state   <= PF_WAIT;
            r_pending <= r_pending | w_seg_done;
          end
          PF_WAIT: begin
            r_shadow     <= bus.i_regf_rd_data[7:3];
            r_shadow_vld <= 1'b1;
            r_pending    <= r_pending | w_seg_done;
            r_state      <= ACTIVE;
          end
          FINISH: begin
            r_hdr_en <= 1'b0;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_regf_rd_en = r_regf_rd_en;
  assign bus.o_regf_addr  = r_regf_addr;
  assign bus.o_hdr_en     = r_hdr_en;
  assign bus.o_cp         = r_cp;
  assign bus.o_toc        = r_toc;
  assign bus.o_mode       = r_mode;
  assign bus.o_fetch_done = r_fetch_done;
  assign bus.o_fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_hdr_cmd_fetch.sv
// Bench for hdr_cmd_fetch: a register-file responder, a read logger and an
// engine-side driver that walks randomized descriptor lists and compares the
// presented descriptors, read addresses and completion flags with a
// list-level model of the fetch rules.
module tb_hdr_cmd_fetch;
  localparam int MAXC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   force_d = -1;

  logic [7:0]  mem [0:4095];
  logic [7:0]  tx_desc [16];
  logic [11:0] rd_log [$];

  hdr_cmd_fetch_if bif ();

  hdr_cmd_fetch #(.CMD_BASE_ADDR(12'd400), .MAX_CMDS(MAXC)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .bus         (bif)
  );

  always #5 clk = ~clk;

  // Register file: data valid the cycle after the read strobe, junk otherwise.
  always @(posedge clk) bif.i_regf_rd_data <= bif.o_regf_rd_en ? mem[bif.o_regf_addr] : 8'($urandom);

  // Log every read address issued.
  always @(posedge clk) if (bif.o_regf_rd_en) rd_log.push_back(bif.o_regf_addr);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bif.o_hdr_en, bif.o_cp, bif.o_toc, bif.o_mode};
  endfunction

  task automatic wait_first(output int lat);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (bif.o_hdr_en || bif.o_fetch_done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One transaction. abort_at: index at which the engine quits early (-1 none);
  // dual: raise a segment-done together with the final hdr_done.
  task automatic run_txn(input int cnt, input int abort_at, input bit dual);
    logic [4:0]  exp_d [$];
    logic [11:0] exp_rd [$];
    bit   valid, exp_err, last_adv;
    int   last, lat, d;
    logic [4:0] e;
    valid = (cnt >= 1) && (cnt <= MAXC);
    mem[400] = 8'(cnt);
    for (int i = 0; i < 16; i++) mem[401 + i] = tx_desc[i];
    rd_log.delete();
    exp_rd.push_back(12'd400);
    if (valid) begin
      for (int i = 0; i < cnt; i++) begin
        e = {tx_desc[i][7], tx_desc[i][6] | (i == cnt - 1), tx_desc[i][5:3]};
        exp_d.push_back(e);
        if (e[3] || e[2:0] != 3'd6 || i == abort_at) break;
      end
      last     = exp_d.size() - 1;
      last_adv = !exp_d[last][3] && exp_d[last][2:0] == 3'd6;
      exp_err  = last < cnt - 1;
      for (int i = 0; i <= last + (last_adv ? 1 : 0); i++) exp_rd.push_back(12'(401 + i));
    end else begin
      last = -1; last_adv = 0; exp_err = 1;
    end

    @(negedge clk); bif.i_hdr_start = 1'b1;
    @(negedge clk); bif.i_hdr_start = 1'b0;
    wait_first(lat);
    check_eq("first_latency", lat, valid ? 4 : 2);
    if (lat < 0) return;
    if (!valid) begin
      check_eq("bad_cnt_done_err", {bif.o_fetch_done, bif.o_fetch_err, bif.o_hdr_en}, 3'b110);
      @(negedge clk);
      check_eq("bad_cnt_pulse_end", {bif.o_fetch_done, bif.o_hdr_en}, 2'b00);
    end else begin
      for (int k = 0; k <= last; k++) begin
        check_eq($sformatf("desc%0d", k), outs(), {1'b1, exp_d[k]});
        if (k < last) begin
          d = (force_d >= 0 && k == 0) ? force_d : int'($urandom_range(0, 3));
          repeat (d) @(negedge clk);
          if (exp_d[k][4]) bif.i_ccc_done = 1'b1; else bif.i_ddr_mode_done = 1'b1;
          bif.i_hdr_start = ($urandom % 4 == 0);
          @(negedge clk);
          bif.i_ccc_done = 1'b0; bif.i_ddr_mode_done = 1'b0; bif.i_hdr_start = 1'b0;
          if (force_d >= 0 && k == 0) begin
            check_eq("pending_hold", outs(), {1'b1, exp_d[0]});
            @(negedge clk);
            check_eq("pending_apply", outs(), {1'b1, exp_d[1]});
            repeat (3) @(negedge clk);
          end else begin
            repeat (5) @(negedge clk);
          end
        end
      end
      if (last_adv) repeat (4) @(negedge clk);
      else repeat ($urandom_range(0, 3)) @(negedge clk);
      bif.i_hdr_done = 1'b1;
      if (dual) bif.i_ddr_mode_done = 1'b1;
      @(negedge clk);
      bif.i_hdr_done = 1'b0; bif.i_ddr_mode_done = 1'b0;
      check_eq("done_err", {bif.o_fetch_done, bif.o_fetch_err}, {1'b1, exp_err});
      check_eq("desc_at_done", {bif.o_cp, bif.o_toc, bif.o_mode}, exp_d[last]);
      @(negedge clk);
      check_eq("done_pulse_end", {bif.o_fetch_done, bif.o_hdr_en}, 2'b00);
    end
    check_eq("read_count", rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check_eq($sformatf("read_addr%0d", i), rd_log[i], exp_rd[i]);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_desc();
    for (int i = 0; i < 16; i++) begin
      tx_desc[i][7]   = 1'($urandom);
      tx_desc[i][6]   = ($urandom % 6 == 0);
      tx_desc[i][5:3] = ($urandom % 8 == 0) ? 3'($urandom) : 3'd6;
      tx_desc[i][2:0] = 3'($urandom);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, ab;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    bif.i_hdr_start = 0; bif.i_ccc_done = 0; bif.i_ddr_mode_done = 0; bif.i_hdr_done = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {outs(), bif.o_regf_rd_en, bif.o_fetch_done, bif.o_fetch_err}, 9'd0);
    check_eq("reset_addr", bif.o_regf_addr, 12'd400);
    rst_n = 1'b1;
    @(negedge clk);

    // Single CCC descriptor.
    rand_desc(); tx_desc[0] = 8'hB0;
    run_txn(1, -1, 0);
    // Three descriptors, last terminator forced.
    tx_desc[0] = 8'h30; tx_desc[1] = 8'hB0; tx_desc[2] = 8'h30;
    run_txn(3, -1, 0);
    // Invalid counts.
    run_txn(0, -1, 0);
    run_txn(9, -1, 0);
    // Segment-done during PF_WAIT gets held and applied one cycle late.
    tx_desc[0] = 8'h30; tx_desc[1] = 8'h30;
    force_d = 2;
    run_txn(2, -1, 0);
    force_d = -1;
    // Early hdr_done with a coincident segment-done.
    tx_desc[0] = 8'h30; tx_desc[1] = 8'h30; tx_desc[2] = 8'h30;
    run_txn(3, 1, 1);

    // Reset in the middle of a transaction.
    tx_desc[0] = 8'h30; tx_desc[1] = 8'hB0; tx_desc[2] = 8'h30;
    mem[400] = 8'd3;
    for (int i = 0; i < 3; i++) mem[401 + i] = tx_desc[i];
    @(negedge clk); bif.i_hdr_start = 1'b1;
    @(negedge clk); bif.i_hdr_start = 1'b0;
    repeat (8) @(negedge clk);
    bif.i_ddr_mode_done = 1'b1;
    @(negedge clk); bif.i_ddr_mode_done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mid_second_desc", outs(), {1'b1, 5'b10110});
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_outs", {outs(), bif.o_regf_rd_en, bif.o_fetch_done, bif.o_fetch_err}, 9'd0);
    check_eq("async_rst_addr", bif.o_regf_addr, 12'd400);
    @(negedge clk);
    check_eq("rst_no_done", bif.o_fetch_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    rand_desc(); tx_desc[0] = 8'h30;
    run_txn(2, -1, 0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      rand_desc();
      cnt = ($urandom % 8 == 0) ? (($urandom % 2 == 0) ? 0 : int'($urandom_range(9, 12)))
                                : int'($urandom_range(1, MAXC));
      ab  = ($urandom % 5 == 0 && cnt > 0) ? int'($urandom_range(0, cnt - 1)) : -1;
      run_txn(cnt, ab, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hdr_cmd_fetch.md
HDR_CMD_FETCH -- requirements
Module: hdr_cmd_fetch

Interface
REQ-001 SHALL have parameter CMD_BASE_ADDR, default 12'd400: regfile address of the command-count byte; descriptors follow at CMD_BASE_ADDR+1..+N.
REQ-002 SHALL have parameter MAX_CMDS, default 8: largest legal command count.
REQ-003 i_sys_clk  in  1  system clock, all state on rising edge.
REQ-004 i_sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_hdr_start  in  1  single-cycle pulse from i3c engine: begin HDR transaction.
REQ-006 i_regf_rd_data  in  8  regfile read data, valid exactly 1 cycle after o_regf_rd_en.
REQ-007 i_ccc_done  in  1  CCC segment complete pulse.
REQ-008 i_ddr_mode_done  in  1  DDR segment complete pulse.
REQ-009 i_hdr_done  in  1  HDR engine transaction complete pulse.
REQ-010 o_regf_rd_en  out  1  regfile read strobe, one cycle per read.
REQ-011 o_regf_addr  out  12  regfile read address.
REQ-012 o_hdr_en  out  1  enable to HDR engine, high for whole transaction.
REQ-013 o_cp  out  1  command present (1 = CCC, 0 = normal DDR) of current descriptor.
REQ-014 o_toc  out  1  term of completion (1 = exit, 0 = restart) of current descriptor.
REQ-015 o_mode  out  3  HDR mode of current descriptor (6 = HDR-DDR).
REQ-016 o_fetch_done  out  1  single-cycle pulse: transaction finished.
REQ-017 o_fetch_err  out  1  single-cycle pulse, coincident with o_fetch_done, on error.

Function
REQ-018 Descriptor byte format SHALL be: bit7 CP, bit6 TOC, bits5:3 MODE, bits2:0 ignored.
REQ-019 States SHALL be IDLE, RD_CNT, WAIT_CNT, RD_DESC, WAIT_DESC, ACTIVE, PREFETCH, PF_WAIT, FINISH.
REQ-020 IDLE: on i_hdr_start go to RD_CNT; i_hdr_start in any other state SHALL be ignored.
REQ-021 RD_CNT: assert o_regf_rd_en with o_regf_addr = CMD_BASE_ADDR for 1 cycle, go to WAIT_CNT.
REQ-022 WAIT_CNT: latch count = i_regf_rd_data; count 0 or > MAX_CMDS -> FINISH with error; else index = 0, go to RD_DESC.
REQ-023 RD_DESC: read address CMD_BASE_ADDR+1+index; WAIT_DESC latches CP/TOC/MODE into outputs, sets o_hdr_en = 1, goes to ACTIVE (first descriptor visible 4 cycles after i_hdr_start).
REQ-024 Last descriptor (index = count-1) SHALL have o_toc forced to 1 regardless of stored bit.
REQ-025 ACTIVE with o_toc = 0 and index+1 < count: go immediately to PREFETCH, read descriptor index+1 into a shadow register (PF_WAIT latches), return to ACTIVE; o_cp/o_toc/o_mode SHALL NOT change during prefetch.
REQ-026 In ACTIVE, i_ccc_done or i_ddr_mode_done with o_toc = 0: on next edge outputs load from shadow, index increments; if the segment-done pulse arrives in PREFETCH/PF_WAIT, it SHALL be held pending and applied the cycle after the shadow is loaded.
REQ-027 o_mode != 6 on any loaded descriptor: block SHALL keep it on outputs (engine exits) and wait for i_hdr_done.
REQ-028 i_hdr_done in ACTIVE/PREFETCH/PF_WAIT -> FINISH; FINISH pulses o_fetch_done 1 cycle, clears o_hdr_en, returns to IDLE.
REQ-029 o_fetch_err SHALL pulse in FINISH if count invalid, or i_hdr_done arrives while descriptors remain (index < count-1).
REQ-030 Simultaneous i_hdr_done and segment-done SHALL be treated as i_hdr_done only.
REQ-031 Index arithmetic SHALL be 4-bit unsigned; address = CMD_BASE_ADDR + 1 + index, no wrap within MAX_CMDS.

Reset
REQ-032 On i_sys_rst_n low, asynchronously: state IDLE, all outputs 0, o_regf_addr = CMD_BASE_ADDR, count/index/shadow/pending cleared.
REQ-033 Reset asserted mid-transaction SHALL abort with no o_fetch_done pulse; o_hdr_en drops immediately.

Verification
REQ-034 Count 1, desc 8'hB0 (CP=1, MODE=6) -> o_hdr_en high, o_cp=1, o_toc=1, o_mode=6; i_hdr_done -> one o_fetch_done, o_fetch_err 0.
REQ-035 Count 3, desc 8'h30, 8'hB0, 8'h30 -> reads at 401..403 in order, outputs switch cycle after each segment-done, last o_toc forced 1.
REQ-036 Count 0 and count 9 -> no descriptor read, o_fetch_done and o_fetch_err pulse together, o_hdr_en never high.
REQ-037 Count 2, i_ddr_mode_done issued the cycle after ACTIVE entry (during PF_WAIT) -> second descriptor applied one cycle late, none lost.
REQ-038 Count 3, reset asserted in ACTIVE after first segment -> all outputs 0 asynchronously; next i_hdr_start restarts from address 400.
